// File: rtl/huffman_pkg.sv
// Shared JPEG DC Huffman definitions: decoder FSM states and the luma/chroma
// DC code tables (right-aligned codes plus their bit lengths, indexed by size).
package huffman_pkg;

  localparam int unsigned MAX_CODE_LEN = 7;
  localparam int unsigned MAX_SIZE     = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CODE,
    ST_MAG,
    ST_OUT
  } dc_state_e;

  // Element [s] is the code for size category s; element 7 is listed first.
  localparam logic [7:0][6:0] LUMA_DC_CODE   = {7'd30, 7'd14, 7'd6, 7'd5, 7'd4, 7'd3, 7'd2, 7'd0};
  localparam logic [7:0][2:0] LUMA_DC_LEN    = {3'd5, 3'd4, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd2};
  localparam logic [7:0][6:0] CHROMA_DC_CODE = {7'd126, 7'd62, 7'd30, 7'd14, 7'd6, 7'd2, 7'd1, 7'd0};
  localparam logic [7:0][2:0] CHROMA_DC_LEN  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd2, 3'd2};

  localparam logic [6:0] LUMA_DC_INVALID     = 7'd31;
  localparam logic [2:0] LUMA_DC_INVALID_LEN = 3'd5;
  localparam logic [6:0] CHROMA_DC_INVALID     = 7'd127;
  localparam logic [2:0] CHROMA_DC_INVALID_LEN = 3'd7;

endpackage

// File: rtl/dc_code_match.sv
// Combinational lookup of a partial DC code (right-aligned, given length)
// against the selected table; flags a hit with its size or an illegal code.
module dc_code_match
  import huffman_pkg::*;
(
  input  logic       index,
  input  logic [2:0] length,
  input  logic [6:0] code,
  output logic       hit,
  output logic [2:0] size,
  output logic       invalid
);

  always_comb begin
    hit  = 1'b0;
    size = '0;
    // Codes are prefix-free, so at most one entry can match.
    for (int unsigned s = 0; s <= MAX_SIZE; s++) begin
      if (index ? (length == CHROMA_DC_LEN[s] && code == CHROMA_DC_CODE[s])
                : (length == LUMA_DC_LEN[s]   && code == LUMA_DC_CODE[s])) begin
        hit  = 1'b1;
        size = 3'(s);
      end
    end
    invalid = index ? (length == CHROMA_DC_INVALID_LEN && code == CHROMA_DC_INVALID)
                    : (length == LUMA_DC_INVALID_LEN   && code == LUMA_DC_INVALID);
  end

endmodule

// File: rtl/huffman_dc_decoder.sv
// Bit-serial JPEG DC decoder: Huffman size code, then magnitude bits,
// producing a registered size category and sign-extended DC difference.
module huffman_dc_decoder
  import huffman_pkg::*;
#(
  parameter int unsigned DIFF_W = 8
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_start,
  input  logic              I_index,
  input  logic              I_bit,
  input  logic              I_bit_valid,
  output logic              O_bit_ready,
  output logic              O_valid,
  input  logic              I_ready,
  output logic [2:0]        O_size,
  output logic [DIFF_W-1:0] O_diff,
  output logic              O_error
);

  dc_state_e         state_q, state_d;
  logic              index_q, index_d;
  logic [6:0]        code_q, code_d;
  logic [2:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [6:0]        mag_q, mag_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        out_size_q, out_size_d;
  logic [DIFF_W-1:0] out_diff_q, out_diff_d;
  logic              out_err_q, out_err_d;

  logic              bit_take;
  logic [6:0]        code_nxt, mag_nxt;
  logic [2:0]        len_nxt, cnt_nxt;
  logic              m_hit, m_invalid;
  logic [2:0]        m_size;
  logic [7:0]        mag_w;
  logic [DIFF_W-1:0] v_ext, range_ext, diff_calc;

  assign O_bit_ready = (state_q == ST_CODE) || (state_q == ST_MAG);
  assign O_valid     = (state_q == ST_OUT);
  assign O_size      = out_size_q;
  assign O_diff      = out_diff_q;
  assign O_error     = out_err_q;

  assign bit_take = I_bit_valid && O_bit_ready;
  assign code_nxt = {code_q[5:0], I_bit};
  assign len_nxt  = len_q + 3'd1;
  assign mag_nxt  = {mag_q[5:0], I_bit};
  assign cnt_nxt  = cnt_q + 3'd1;

  // Match on the code including the bit being taken this cycle.
  dc_code_match u_match (
    .index   (index_q),
    .length  (len_nxt),
    .code    (code_nxt),
    .hit     (m_hit),
    .size    (m_size),
    .invalid (m_invalid)
  );

  // Negative differences are sent as the one's complement of |diff|.
  always_comb begin
    mag_w     = {1'b0, mag_nxt};
    v_ext     = DIFF_W'(mag_nxt);
    range_ext = (DIFF_W'(1) << size_q) - DIFF_W'(1);
    diff_calc = mag_w[size_q - 3'd1] ? v_ext : v_ext - range_ext;
  end

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    code_d     = code_q;
    len_d      = len_q;
    size_d     = size_q;
    mag_d      = mag_q;
    cnt_d      = cnt_q;
    out_size_d = out_size_q;
    out_diff_d = out_diff_q;
    out_err_d  = out_err_q;
    case (state_q)
      ST_IDLE: begin
        if (I_start) begin
          state_d = ST_CODE;
          index_d = I_index;
          code_d  = '0;
          len_d   = '0;
        end
      end
      ST_CODE: begin
        if (bit_take) begin
          code_d = code_nxt;
          len_d  = len_nxt;
          if (m_invalid) begin
            state_d    = ST_OUT;
            out_size_d = '0;
            out_diff_d = '0;
            out_err_d  = 1'b1;
          end else if (m_hit && m_size == 3'd0) begin
            state_d    = ST_OUT;
            out_size_d = '0;
            out_diff_d = '0;
            out_err_d  = 1'b0;
          end else if (m_hit) begin
            state_d = ST_MAG;
            size_d  = m_size;
            mag_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      ST_MAG: begin
        if (bit_take) begin
          mag_d = mag_nxt;
          cnt_d = cnt_nxt;
          if (cnt_nxt == size_q) begin
            state_d    = ST_OUT;
            out_size_d = size_q;
            out_diff_d = diff_calc;
            out_err_d  = 1'b0;
          end
        end
      end
      ST_OUT: begin
        if (I_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state_q    <= ST_IDLE;
      index_q    <= 1'b0;
      code_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      mag_q      <= '0;
      cnt_q      <= '0;
      out_size_q <= '0;
      out_diff_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      code_q     <= code_d;
      len_q      <= len_d;
      size_q     <= size_d;
      mag_q      <= mag_d;
      cnt_q      <= cnt_d;
      out_size_q <= out_size_d;
      out_diff_q <= out_diff_d;
      out_err_q  <= out_err_d;
    end
  end

endmodule

// File: tb/tb_huffman_dc_decoder.sv
// Directed bench for huffman_dc_decoder: a string-level table/arithmetic model
// checked every output cycle, plus hand-computed literal results per decode.
module tb_huffman_dc_decoder;

  logic       I_clk = 1'b0;
  logic       I_rst_n, I_start, I_index, I_bit, I_bit_valid, I_ready;
  logic       O_bit_ready, O_valid, O_error;
  logic [2:0] O_size;
  logic [7:0] O_diff;

  always #5 I_clk = ~I_clk;

  huffman_dc_decoder #(.DIFF_W(8)) dut (
    .I_clk       (I_clk),
    .I_rst_n     (I_rst_n),
    .I_start     (I_start),
    .I_index     (I_index),
    .I_bit       (I_bit),
    .I_bit_valid (I_bit_valid),
    .O_bit_ready (O_bit_ready),
    .O_valid     (O_valid),
    .I_ready     (I_ready),
    .O_size      (O_size),
    .O_diff      (O_diff),
    .O_error     (O_error)
  );

  int total = 0;
  int bad   = 0;

  bit exp_valid = 1'b0;
  int exp_size, exp_diff, exp_used;
  bit exp_err;

  string luma_t[8]   = '{"00", "010", "011", "100", "101", "110", "1110", "11110"};
  string chroma_t[8] = '{"00", "01", "10", "110", "1110", "11110", "111110", "1111110"};

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Decode a '0'/'1' string by prefix lookup, then apply the JPEG magnitude rule.
  function automatic void model(input bit idx, input string s, output int sz,
                                output int df, output bit er, output int used);
    bit    found;
    string pre, inv;
    int    v;
    sz = 0; df = 0; er = 1'b0; used = 0; found = 1'b0;
    if (idx) inv = "1111111"; else inv = "11111";
    for (int l = 1; l <= 7; l++) begin
      if (!found) begin
        pre = s.substr(0, l - 1);
        for (int k = 0; k < 8; k++) begin
          if (pre == (idx ? chroma_t[k] : luma_t[k])) begin
            found = 1'b1; sz = k; used = l;
          end
        end
        if (!found && pre == inv) begin
          found = 1'b1; er = 1'b1; used = l;
        end
      end
    end
    if (!er) begin
      v = 0;
      for (int i = 0; i < sz; i++) v = v * 2 + ((s[used + i] == "1") ? 1 : 0);
      if (sz == 0)                 df = 0;
      else if (v >= (1 << (sz - 1))) df = v;
      else                         df = v - ((1 << sz) - 1);
      used += sz;
    end
  endfunction

  always @(negedge I_clk) begin
    if (I_rst_n) begin
      if (exp_valid && O_valid) begin
        chk("model_size", O_size, exp_size);
        chk("model_diff", $signed(O_diff), exp_diff);
        chk("model_err", O_error, exp_err);
      end else if (!exp_valid) begin
        chk("idle_valid", O_valid, 0);
      end
    end
  end

  task automatic run(input bit idx, input string s, input bit toggle, input int hold,
                     input int lsz, input int ldf, input bit ler);
    int  used, stalls, n, p;
    bit  done, bv, rdy;
    model(idx, s, exp_size, exp_diff, exp_err, exp_used);
    exp_valid = 1'b1;
    I_start = 1'b1; I_index = idx;
    @(posedge I_clk); #1;
    I_start = 1'b0; I_index = ~idx;
    used = 0; stalls = 0; n = 0; p = 0; done = 1'b0;
    while (!done && n < 40) begin
      bv = toggle ? (n % 2 == 0) : 1'b1;
      I_bit_valid = bv;
      I_bit = (p < s.len()) ? (s[p] == "1") : 1'b0;
      rdy = O_bit_ready;
      @(posedge I_clk);
      if (bv && rdy) begin used++; p++; end
      else if (rdy) stalls++;
      #1;
      n++;
      if (O_valid) done = 1'b1;
    end
    I_bit_valid = 1'b0;
    chk({s, "_done"}, done, 1);
    chk({s, "_latency"}, n, exp_used + stalls);
    chk({s, "_consumed"}, used, exp_used);
    chk({s, "_lit_size"}, O_size, lsz);
    chk({s, "_lit_diff"}, $signed(O_diff), ldf);
    chk({s, "_lit_err"}, O_error, ler);
    for (int h = 0; h < hold; h++) begin
      chk({s, "_hold_ready"}, O_bit_ready, 0);
      chk({s, "_hold_valid"}, O_valid, 1);
      @(posedge I_clk); #1;
    end
    I_ready = 1'b1;
    @(posedge I_clk); #1;
    I_ready = 1'b0;
    chk({s, "_after_hs"}, O_valid, 0);
    exp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string rs;
    I_rst_n = 1'b0; I_start = 1'b0; I_index = 1'b0;
    I_bit = 1'b0; I_bit_valid = 1'b0; I_ready = 1'b0;
    repeat (3) @(posedge I_clk);
    #1;
    chk("rst_ready", O_bit_ready, 0);
    chk("rst_valid", O_valid, 0);
    chk("rst_size", O_size, 0);
    chk("rst_diff", O_diff, 0);
    chk("rst_err", O_error, 0);
    I_rst_n = 1'b1;
    @(posedge I_clk); #1;

    run(1'b0, "00",             1'b0, 0, 0,    0,    1'b0);
    run(1'b0, "100101",         1'b0, 0, 3,    5,    1'b0);
    run(1'b1, "110010",         1'b0, 0, 3,   -5,    1'b0);
    run(1'b0, "111100000000",   1'b0, 0, 7, -127,    1'b0);
    run(1'b1, "11111101111111", 1'b0, 0, 7,  127,    1'b0);
    run(1'b1, "010",            1'b0, 0, 1,   -1,    1'b0);
    run(1'b0, "111111",         1'b0, 0, 0,    0,    1'b1);
    run(1'b1, "11111111",       1'b0, 0, 0,    0,    1'b1);
    run(1'b0, "100101",         1'b1, 3, 3,    5,    1'b0);
    run(1'b1, "110010",         1'b1, 3, 3,   -5,    1'b0);

    // Chroma size-5 decode interrupted by reset after two magnitude bits.
    I_start = 1'b1; I_index = 1'b1;
    @(posedge I_clk); #1;
    I_start = 1'b0;
    rs = "1111010";
    for (int i = 0; i < 7; i++) begin
      I_bit_valid = 1'b1;
      I_bit = (rs[i] == "1");
      @(posedge I_clk); #1;
    end
    chk("mid_mag_ready", O_bit_ready, 1);
    chk("mid_mag_valid", O_valid, 0);
    I_rst_n = 1'b0; I_bit = 1'b1;
    @(posedge I_clk); #1;
    chk("mrst_ready", O_bit_ready, 0);
    chk("mrst_valid", O_valid, 0);
    chk("mrst_size", O_size, 0);
    chk("mrst_diff", O_diff, 0);
    chk("mrst_err", O_error, 0);
    I_rst_n = 1'b1;
    @(posedge I_clk); #1;
    chk("mrst_idle_ready", O_bit_ready, 0);
    I_bit_valid = 1'b0;

    run(1'b0, "0101", 1'b0, 0, 1, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/huffman_dc_decoder.md
# huffman_dc_decoder

Bit-serial decoder for JPEG DC coefficients: consumes an MSB-first bitstream holding one DC Huffman code plus its magnitude bits, and returns the size category and the signed DC difference. It mirrors the encoder-side DC Huffman table, with the same luma/chroma selection and the same size range 0..7. It sits in the decode/loopback-check path, fed by a bitstream unpacker and feeding DC prediction reconstruction.

## Interface
- DIFF_W, 8, width of O_diff; must be ≥ 8 (size 7 spans −127..+127).
- I_clk  in  1  clock.
- I_rst_n  in  1  reset: synchronous, active-low, sampled on rising I_clk.
- I_start  in  1  request a new DC decode; accepted only in IDLE.
- I_index  in  1  table select (0 = luminance, 1 = chrominance); sampled only when I_start is accepted.
- I_bit  in  1  next stream bit, MSB-first.
- I_bit_valid  in  1  I_bit is valid.
- O_bit_ready  out  1  decoder can take a bit; high in CODE and MAG only.
- O_valid  out  1  result available; held until accepted.
- I_ready  in  1  downstream accepts the result.
- O_size  out  3  decoded size category.
- O_diff  out  DIFF_W  signed DC difference.
- O_error  out  1  code not in table; qualified by O_valid.

## Operation
- States: IDLE, CODE, MAG, OUT.
  - IDLE → CODE on I_start. I_index is latched on that transition.
  - CODE → MAG on a code match with size > 0.
  - CODE → OUT on a match with size 0, or on an invalid code.
  - MAG → OUT when `size` magnitude bits have been taken.
  - OUT → IDLE when I_valid/I_ready handshake completes (O_valid && I_ready).
- A bit is consumed only when I_bit_valid && O_bit_ready. Cycles with I_bit_valid low stall the decoder without changing state.
- CODE:
  - Shift each consumed bit into a 7-bit code register and increment a length counter.
  - After every bit, match (index, length, code) against the table below.
- Luma table (code → size): 00→0, 010→1, 011→2, 100→3, 101→4, 110→5, 1110→6, 11110→7.
- Chroma table (code → size): 00→0, 01→1, 10→2, 110→3, 1110→4, 11110→5, 111110→6, 1111110→7.
- Invalid codes: 11111 (luma, 5th bit) and 1111111 (chroma, 7th bit).
  - Result is O_error = 1, O_size = 0, O_diff = 0.
  - No further bits are consumed for that decode.
- MAG:
  - Shift in exactly `size` bits, MSB-first, to form the raw value v.
  - If the MSB of v is 1, diff = +v. Otherwise diff = v − (2^size − 1).
  - Size 0 gives diff = 0.
  - O_diff is sign-extended to DIFF_W.
- I_start outside IDLE is ignored. I_bit_valid in IDLE/OUT is ignored; no bit is consumed.

## Timing
- Reset values: state IDLE; O_bit_ready, O_valid, O_error = 0; O_size = 0; O_diff = 0. Code register and counters are cleared.
- Reset asserted mid-decode (any state): return to IDLE on the next edge. Partial code/magnitude bits are discarded and a pending result is dropped.
- I_start accepted at edge t → O_bit_ready high from cycle t+1.
- Throughput: one bit per cycle while I_bit_valid is high.
- Latency: the last bit (final code bit for size 0/error, else final magnitude bit) is consumed at edge k → O_valid = 1 in cycle k+1, with O_size/O_diff/O_error registered.
  - Minimum: start at t, bits at t+1 and t+2, O_valid at t+3.
  - Maximum with no stalls: 7 code bits + 7 magnitude bits.
- O_valid, O_size, O_diff and O_error stay stable while I_ready is low.
- Handshake at edge h → O_valid = 0 and IDLE in cycle h+1. The next I_start is accepted at h+1 at the earliest (one bubble).
- There is no cross-stage forwarding. A bit present during the same cycle as the final match is not consumed by the next state.

## Structure
- Shared package huffman_pkg holds:
  - state enum;
  - MAX_CODE_LEN = 7 and MAX_SIZE = 7;
  - luma/chroma DC code/length constants, shared with the encoder-side table so both directions use one source.
- Sub-module dc_code_match: combinational (index, length, code) → hit, size, invalid.
- The top level contains the FSM, shift registers, counter and magnitude-to-diff conversion.

## Test plan
- Luma, I_start, bits 00 → O_valid at start+3, O_size = 0, O_diff = 0, O_error = 0.
- Luma, bits 100 then 101 → O_size = 3, O_diff = +5. Chroma, bits 110 then 010 → O_size = 3, O_diff = −5.
- Luma 11110 + 0000000 → size 7, diff −127. Chroma 1111110 + 1111111 → size 7, diff +127. Chroma 01 + 0 → size 1, diff −1.
- Luma 11111 → O_error = 1 after the 5th bit, no 6th bit consumed. Chroma 1111111 → O_error = 1.
- I_bit_valid toggling 1-0-1 and I_ready low for 3 cycles → same results, outputs stable while held, O_bit_ready low in OUT.
- I_rst_n low during MAG of a size-5 decode → next cycle IDLE, all outputs 0. A following luma 010 + 1 decode → size 1, diff +1.
